// File: rtl/mario_pkg.sv
// Shared types and helpers for the Mario movement logic.
// Holds the state encoding, the default HID keycodes and a saturating clamp.
// No logic of its own; imported by the key scanner and the motion FSM.
package mario_pkg;

  typedef enum logic [2:0] {
    STANDING = 3'd0,
    WALK_L   = 3'd1,
    WALK_R   = 3'd2,
    JUMP     = 3'd3,
    FALL     = 3'd4
  } mario_state_t;

  // USB HID usage IDs for A, D and space.
  localparam logic [7:0] KEYCODE_A     = 8'h04;
  localparam logic [7:0] KEYCODE_D     = 8'h07;
  localparam logic [7:0] KEYCODE_SPACE = 8'h2C;

  // Saturate v into [lo, hi].
  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/mario_key_scan.sv
// Scans all HID keycode slots for the left, right and jump keys.
// Purely combinational: zero latency, no flow control.
// Empty slots (8'h00) never match because none of the keycodes is zero.
module mario_key_scan #(
  parameter int         NUM_KEYS  = 6,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP  = 8'h2C
) (
  input  logic [8*NUM_KEYS-1:0] keycodes,
  output logic                  left_h,
  output logic                  right_h,
  output logic                  jump_h
);

  // OR together a match from every slot.
  always_comb begin
    left_h  = 1'b0;
    right_h = 1'b0;
    jump_h  = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keycodes[8*i +: 8] == KEY_LEFT)  left_h  = 1'b1;
      if (keycodes[8*i +: 8] == KEY_RIGHT) right_h = 1'b1;
      if (keycodes[8*i +: 8] == KEY_JUMP)  jump_h  = 1'b1;
    end
  end

endmodule

// File: rtl/mario_motion_fsm.sv
// Player movement FSM: keys + collision flags -> registered signed per-frame velocities.
// State advances only on frame_tick; outputs update on the edge that samples it.
// Synchronous active-low Reset overrides frame_tick.
module mario_motion_fsm
  import mario_pkg::*;
#(
  parameter int         NUM_KEYS   = 6,
  parameter int         VEL_W      = 10,
  parameter int         MAX_WALK   = 4,
  parameter int         WALK_ACCEL = 1,
  parameter int         JUMP_VEL   = 12,
  parameter int         GRAVITY    = 1,
  parameter int         MAX_FALL   = 8,
  parameter int         JUMP_HOLD  = 6,
  parameter int         COYOTE     = 3,
  parameter logic [7:0] KEY_LEFT   = KEYCODE_A,
  parameter logic [7:0] KEY_RIGHT  = KEYCODE_D,
  parameter logic [7:0] KEY_JUMP   = KEYCODE_SPACE
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_tick,
  input  logic                    is_ground,
  input  logic                    hit_ceiling,
  input  logic [8*NUM_KEYS-1:0]   keycodes,
  output logic signed [VEL_W-1:0] vel_x,
  output logic signed [VEL_W-1:0] vel_y,
  output logic [2:0]              state_o,
  output logic                    facing_right,
  output logic                    stand_still,
  output logic                    airborne
);

  localparam int HW = (JUMP_HOLD < 1) ? 1 : $clog2(JUMP_HOLD + 1);
  localparam int CW = (COYOTE < 1) ? 1 : $clog2(COYOTE + 1);
  localparam logic signed [VEL_W:0] ACC_W  = (VEL_W+1)'(WALK_ACCEL);
  localparam logic signed [VEL_W:0] GRAV_W = (VEL_W+1)'(GRAVITY);

  // Velocity limits must be representable as positive signed VEL_W values.
  if (JUMP_VEL >= 2**(VEL_W-1) || MAX_FALL >= 2**(VEL_W-1) || MAX_WALK >= 2**(VEL_W-1)) begin : g_param_err
    $error("mario_motion_fsm: JUMP_VEL, MAX_FALL and MAX_WALK must be below 2**(VEL_W-1)");
  end

  logic left_h, right_h, jump_h;

  mario_key_scan #(
    .NUM_KEYS (NUM_KEYS),
    .KEY_LEFT (KEY_LEFT),
    .KEY_RIGHT(KEY_RIGHT),
    .KEY_JUMP (KEY_JUMP)
  ) u_key_scan (
    .keycodes(keycodes),
    .left_h  (left_h),
    .right_h (right_h),
    .jump_h  (jump_h)
  );

  mario_state_t            state_q, state_d, gnd_state;
  logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic signed [VEL_W-1:0] vy_grav, vy_jump;
  logic signed [VEL_W:0]   vx_ext, vx_up, vx_dn, vy_ext, vy_g;
  logic [HW-1:0]           hold_q, hold_d;
  logic [CW-1:0]           coyote_q, coyote_d, coyote_dec;
  logic                    facing_q, facing_d, stand_q, stand_d, air_q, air_d;
  logic                    jump_prev_q;
  logic                    left_only, right_only, jump_edge, hold_live;
  int                      tgt;

  // Next-state and datapath for one frame, assuming frame_tick is high.
  always_comb begin
    // Holding both directions cancels out.
    left_only  = left_h & ~right_h;
    right_only = right_h & ~left_h;
    jump_edge  = jump_h & ~jump_prev_q;

    // Horizontal: step toward the target, never past it. Sums are one bit wider.
    tgt    = left_only ? -MAX_WALK : (right_only ? MAX_WALK : 0);
    vx_ext = {vel_x_q[VEL_W-1], vel_x_q};
    vx_up  = vx_ext + ACC_W;
    vx_dn  = vx_ext - ACC_W;
    if (int'(vx_ext) < tgt)      vel_x_d = VEL_W'(clamp(int'(vx_up), -MAX_WALK, tgt));
    else if (int'(vx_ext) > tgt) vel_x_d = VEL_W'(clamp(int'(vx_dn), tgt, MAX_WALK));
    else                         vel_x_d = vel_x_q;

    if (vel_x_d == '0)         gnd_state = STANDING;
    else if (vel_x_d[VEL_W-1]) gnd_state = WALK_L;
    else                       gnd_state = WALK_R;

    // Vertical: gravity saturates at terminal velocity; a live hold freezes vel_y.
    vy_ext     = {vel_y_q[VEL_W-1], vel_y_q};
    vy_g       = vy_ext + GRAV_W;
    vy_grav    = VEL_W'(clamp(int'(vy_g), -JUMP_VEL, MAX_FALL));
    hold_live  = jump_h && (hold_q != '0);
    vy_jump    = hold_live ? vel_y_q : vy_grav;
    coyote_dec = (coyote_q == '0) ? '0 : coyote_q - 1'b1;

    state_d  = state_q;
    vel_y_d  = vel_y_q;
    hold_d   = hold_q;
    coyote_d = coyote_q;

    case (state_q)
      STANDING, WALK_L, WALK_R: begin
        vel_y_d  = '0;
        state_d  = gnd_state;
        coyote_d = is_ground ? CW'(COYOTE) : coyote_dec;
        // Coyote check uses the count before this frame's decrement.
        if (jump_edge && (is_ground || coyote_q != '0)) begin
          vel_y_d = VEL_W'(-JUMP_VEL);
          hold_d  = HW'(JUMP_HOLD);
          state_d = JUMP;
        end else if (!is_ground && coyote_dec == '0) begin
          state_d = FALL;
        end
      end
      JUMP: begin
        if (hit_ceiling) begin
          vel_y_d = '0;
          hold_d  = '0;
          state_d = FALL;
        end else begin
          vel_y_d = vy_jump;
          // Once the key is released the hold is gone for this jump.
          hold_d  = hold_live ? hold_q - 1'b1 : '0;
          if (!vy_jump[VEL_W-1]) state_d = FALL;
        end
      end
      FALL: begin
        hold_d = '0;
        // vel_y is already non-negative here, so a ceiling contact has nothing to stop.
        if (is_ground) begin
          vel_y_d  = '0;
          coyote_d = CW'(COYOTE);
          state_d  = gnd_state;
        end else begin
          vel_y_d = vy_grav;
        end
      end
      default: begin
        vel_y_d = '0;
        hold_d  = '0;
        state_d = STANDING;
      end
    endcase

    facing_d = left_only ? 1'b0 : (right_only ? 1'b1 : facing_q);
    stand_d  = (state_d == STANDING) && (vel_x_d == '0);
    air_d    = (state_d == JUMP) || (state_d == FALL);
  end

  // Register all state and outputs once per frame; Reset wins over frame_tick.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= STANDING;
      vel_x_q     <= '0;
      vel_y_q     <= '0;
      hold_q      <= '0;
      coyote_q    <= CW'(COYOTE);
      jump_prev_q <= 1'b0;
      facing_q    <= 1'b1;
      stand_q     <= 1'b1;
      air_q       <= 1'b0;
    end else if (frame_tick) begin
      state_q     <= state_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      hold_q      <= hold_d;
      coyote_q    <= coyote_d;
      jump_prev_q <= jump_h;
      facing_q    <= facing_d;
      stand_q     <= stand_d;
      air_q       <= air_d;
    end
  end

  assign vel_x        = vel_x_q;
  assign vel_y        = vel_y_q;
  assign state_o      = state_q;
  assign facing_right = facing_q;
  assign stand_still  = stand_q;
  assign airborne     = air_q;

endmodule

// File: tb/tb_mario_motion_fsm.sv
// Self-checking bench for mario_motion_fsm: walk table plus jump/ceiling/coyote/reset sequences.
// Expected values come from constants and simple arithmetic on the documented behaviour.
// Each frame pushes its expectation to a queue that is popped once the DUT has updated.
module tb_mario_motion_fsm;

  localparam int NK = 6;
  localparam int VW = 10;

  localparam logic [2:0] ST_STAND = 3'd0;
  localparam logic [2:0] ST_WL    = 3'd1;
  localparam logic [2:0] ST_WR    = 3'd2;
  localparam logic [2:0] ST_JUMP  = 3'd3;
  localparam logic [2:0] ST_FALL  = 3'd4;

  localparam logic [47:0] K_NONE = 48'h000000000000;
  localparam logic [47:0] K_D    = 48'h000007000000;  // D in slot 3
  localparam logic [47:0] K_A    = 48'h040000000000;  // A in slot 5
  localparam logic [47:0] K_SP   = 48'h00000000002C;  // space in slot 0
  localparam logic [47:0] K_AD   = 48'h040007000000;
  localparam logic [47:0] K_ADSP = 48'h04000700002C;

  logic                 Clk = 1'b0;
  logic                 Reset = 1'b0;
  logic                 frame_tick = 1'b0;
  logic                 is_ground = 1'b1;
  logic                 hit_ceiling = 1'b0;
  logic [8*NK-1:0]      keycodes = '0;
  logic signed [VW-1:0] vel_x, vel_y;
  logic [2:0]           state_o;
  logic                 facing_right, stand_still, airborne;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [47:0] keys;
    logic        gnd;
    int          vx;
    logic [2:0]  st;
    logic        fr;
    logic        ss;
  } vec_t;

  typedef struct {
    string      name;
    int         vx;
    int         vy;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  vec_t walk_tbl[16];

  mario_motion_fsm dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_tick  (frame_tick),
    .is_ground   (is_ground),
    .hit_ceiling (hit_ceiling),
    .keycodes    (keycodes),
    .vel_x       (vel_x),
    .vel_y       (vel_y),
    .state_o     (state_o),
    .facing_right(facing_right),
    .stand_still (stand_still),
    .airborne    (airborne)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT now shows.
  task automatic check_out();
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
    end else begin
      e = exp_q.pop_front();
      if (int'(vel_x) != e.vx || int'(vel_y) != e.vy || state_o !== e.st) begin
        n_fail++;
        $display("FAIL %s: got vx=%0d vy=%0d st=%0d, want vx=%0d vy=%0d st=%0d",
                 e.name, vel_x, vel_y, state_o, e.vx, e.vy, e.st);
      end
    end
  endtask

  // One frame: drive inputs, pulse frame_tick, queue expectation, compare after the edge.
  task automatic step(input logic [47:0] k, input logic g, input logic c,
                      input int vx, input int vy, input logic [2:0] st, input string name);
    exp_t e;
    @(negedge Clk);
    keycodes    = k;
    is_ground   = g;
    hit_ceiling = c;
    frame_tick  = 1'b1;
    e.name = name; e.vx = vx; e.vy = vy; e.st = st;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    frame_tick  = 1'b0;
    hit_ceiling = 1'b0;
    check_out();
  endtask

  task automatic do_reset(input logic ft, input string name);
    exp_t e;
    @(negedge Clk);
    Reset      = 1'b0;
    frame_tick = ft;
    e.name = name; e.vx = 0; e.vy = 0; e.st = ST_STAND;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    check_out();
    check_bit({name, "_facing"}, facing_right, 1'b1);
    check_bit({name, "_stand"},  stand_still,  1'b1);
    check_bit({name, "_air"},    airborne,     1'b0);
    @(negedge Clk);
    Reset      = 1'b1;
    frame_tick = 1'b0;
  endtask

  initial begin
    int vy;
    int apex_tap, apex_hold;

    walk_tbl[0]  = '{K_D,    1'b1,  1, ST_WR,    1'b1, 1'b0};
    walk_tbl[1]  = '{K_D,    1'b1,  2, ST_WR,    1'b1, 1'b0};
    walk_tbl[2]  = '{K_D,    1'b1,  3, ST_WR,    1'b1, 1'b0};
    walk_tbl[3]  = '{K_D,    1'b1,  4, ST_WR,    1'b1, 1'b0};
    walk_tbl[4]  = '{K_D,    1'b1,  4, ST_WR,    1'b1, 1'b0};
    walk_tbl[5]  = '{K_D,    1'b1,  4, ST_WR,    1'b1, 1'b0};
    walk_tbl[6]  = '{K_NONE, 1'b1,  3, ST_WR,    1'b1, 1'b0};
    walk_tbl[7]  = '{K_NONE, 1'b1,  2, ST_WR,    1'b1, 1'b0};
    walk_tbl[8]  = '{K_NONE, 1'b1,  1, ST_WR,    1'b1, 1'b0};
    walk_tbl[9]  = '{K_NONE, 1'b1,  0, ST_STAND, 1'b1, 1'b1};
    walk_tbl[10] = '{K_A,    1'b1, -1, ST_WL,    1'b0, 1'b0};
    walk_tbl[11] = '{K_A,    1'b1, -2, ST_WL,    1'b0, 1'b0};
    walk_tbl[12] = '{K_AD,   1'b1, -1, ST_WL,    1'b0, 1'b0};
    walk_tbl[13] = '{K_AD,   1'b1,  0, ST_STAND, 1'b0, 1'b1};
    walk_tbl[14] = '{K_D,    1'b1,  1, ST_WR,    1'b1, 1'b0};
    walk_tbl[15] = '{K_NONE, 1'b1,  0, ST_STAND, 1'b1, 1'b1};

    // Reset state, with frame_tick low.
    do_reset(1'b0, "reset_initial");

    // Walk table: accelerate, saturate, decelerate, turn, cancel.
    for (int i = 0; i < 16; i++) begin
      step(walk_tbl[i].keys, walk_tbl[i].gnd, 1'b0, walk_tbl[i].vx, 0, walk_tbl[i].st, $sformatf("walk[%0d]", i));
      check_bit($sformatf("walk[%0d]_facing", i), facing_right, walk_tbl[i].fr);
      check_bit($sformatf("walk[%0d]_stand", i),  stand_still,  walk_tbl[i].ss);
      check_bit($sformatf("walk[%0d]_air", i),    airborne,     1'b0);
    end

    // Without frame_tick nothing moves even with keys pressed and ground lost.
    @(negedge Clk);
    keycodes  = K_A;
    is_ground = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    exp_q.push_back('{"no_tick_hold", 0, 0, ST_STAND});
    check_out();
    check_bit("no_tick_facing", facing_right, 1'b1);

    // Tap space: rise -12..-1, FALL at 0, gravity to terminal +8, then land.
    do_reset(1'b0, "reset_tap");
    apex_tap = 0;
    step(K_SP, 1'b1, 1'b0, 0, -12, ST_JUMP, "tap_launch");
    check_bit("tap_air", airborne, 1'b1);
    apex_tap += -int'(vel_y);
    for (int i = 1; i <= 12; i++) begin
      vy = -12 + i;
      step(K_NONE, 1'b0, 1'b0, 0, vy, (vy >= 0) ? ST_FALL : ST_JUMP, $sformatf("tap_rise[%0d]", i));
      if (vel_y < 0) apex_tap += -int'(vel_y);
    end
    for (int j = 1; j <= 10; j++)
      step(K_NONE, 1'b0, 1'b0, 0, (j > 8) ? 8 : j, ST_FALL, $sformatf("tap_fall[%0d]", j));
    check_bit("fall_air", airborne, 1'b1);
    step(K_NONE, 1'b1, 1'b0, 0, 0, ST_STAND, "tap_land");
    check_bit("land_air",   airborne,    1'b0);
    check_bit("land_stand", stand_still, 1'b1);

    // Hold space 10 frames: 7 frames at -12, then gravity resumes.
    do_reset(1'b0, "reset_hold");
    apex_hold = 0;
    step(K_SP, 1'b1, 1'b0, 0, -12, ST_JUMP, "hold_launch");
    apex_hold += -int'(vel_y);
    for (int i = 2; i <= 10; i++) begin
      vy = (i <= 7) ? -12 : -12 + (i - 7);
      step(K_SP, 1'b0, 1'b0, 0, vy, ST_JUMP, $sformatf("hold[%0d]", i));
      if (vel_y < 0) apex_hold += -int'(vel_y);
    end
    for (int v = -8; v <= 0; v++) begin
      step(K_NONE, 1'b0, 1'b0, 0, v, (v >= 0) ? ST_FALL : ST_JUMP, $sformatf("hold_rise[%0d]", v));
      if (vel_y < 0) apex_hold += -int'(vel_y);
    end
    check_bit("hold_apex_higher", apex_hold > apex_tap, 1'b1);

    // Ceiling bump at vel_y = -9.
    do_reset(1'b0, "reset_ceil");
    step(K_SP,   1'b1, 1'b0, 0, -12, ST_JUMP, "ceil_launch");
    step(K_NONE, 1'b0, 1'b0, 0, -11, ST_JUMP, "ceil_rise1");
    step(K_NONE, 1'b0, 1'b0, 0, -10, ST_JUMP, "ceil_rise2");
    step(K_NONE, 1'b0, 1'b0, 0,  -9, ST_JUMP, "ceil_rise3");
    step(K_NONE, 1'b0, 1'b1, 0,   0, ST_FALL, "ceil_bump");
    step(K_NONE, 1'b0, 1'b0, 0,   1, ST_FALL, "ceil_after");

    // Coyote time: press on 2nd frame off the ledge is accepted.
    do_reset(1'b0, "reset_coy1");
    step(K_NONE, 1'b0, 1'b0, 0,   0, ST_STAND, "ledge1_t1");
    step(K_SP,   1'b0, 1'b0, 0, -12, ST_JUMP,  "coyote_jump");

    // Press on 4th frame: already falling, jump ignored.
    do_reset(1'b0, "reset_coy2");
    step(K_NONE, 1'b0, 1'b0, 0, 0, ST_STAND, "ledge2_t1");
    step(K_NONE, 1'b0, 1'b0, 0, 0, ST_STAND, "ledge2_t2");
    step(K_NONE, 1'b0, 1'b0, 0, 0, ST_FALL,  "ledge2_t3");
    step(K_SP,   1'b0, 1'b0, 0, 1, ST_FALL,  "late_jump_ignored");

    // A+D held during a jump decays vel_x; Reset mid-jump with frame_tick high.
    do_reset(1'b0, "reset_ad");
    step(K_D,    1'b1, 1'b0, 1,   0, ST_WR,   "ad_walk1");
    step(K_D,    1'b1, 1'b0, 2,   0, ST_WR,   "ad_walk2");
    step(K_D,    1'b1, 1'b0, 3,   0, ST_WR,   "ad_walk3");
    step(K_ADSP, 1'b1, 1'b0, 2, -12, ST_JUMP, "ad_launch");
    step(K_ADSP, 1'b0, 1'b0, 1, -12, ST_JUMP, "ad_decay1");
    step(K_ADSP, 1'b0, 1'b0, 0, -12, ST_JUMP, "ad_decay2");
    check_bit("ad_facing", facing_right, 1'b1);
    do_reset(1'b1, "reset_midjump");
    step(K_NONE, 1'b1, 1'b0, 0, 0, ST_STAND, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
